// File: rtl/sha256_coef_reader.sv
// Reader for the registered SHA-256 K ROM: issues indices, absorbs the 1-cycle read latency, streams K_t with a round tag.
// Optional running XOR of delivered coefficients (o_coef_xor) is enabled by defining SHA256_COEF_XOR_EN.
module sha256_coef_reader #(
  parameter int ROUNDS = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_coef_num,
  input  logic [DATA_W-1:0] i_coef_value,
  output logic              o_k_valid,
  input  logic              i_k_ready,
  output logic [DATA_W-1:0] o_k_value,
  output logic [ADDR_W-1:0] o_k_round,
`ifdef SHA256_COEF_XOR_EN
  output logic [DATA_W-1:0] o_coef_xor,
`endif
  output logic              o_k_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROUNDS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] flight_tag;
  logic              inflight;
  logic [1:0]        occ;
  logic [DATA_W-1:0] fifo_value [2];
  logic [ADDR_W-1:0] fifo_round [2];
  logic              done_q;
  logic              pop;
  logic              issue;
  logic              start_run;
  logic              drain_empty;
  logic              wr_slot;
  logic [1:0]        occ_after_pop;
  logic [1:0]        credits_used;

  // Credits count the slot freed by this cycle's pop, so a full-rate stream never bubbles.
  always_comb begin
    pop           = (occ != 2'd0) && i_k_ready;
    occ_after_pop = occ - {1'b0, pop};
    credits_used  = occ_after_pop + {1'b0, inflight};
    wr_slot       = occ_after_pop[0];
    drain_empty   = (occ_after_pop == 2'd0) && !inflight;
    start_run     = (state_q == IDLE) && i_start && !i_abort;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (issue && (issue_cnt == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (drain_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_abort) state_d = IDLE;
  end

  always_comb begin
    o_busy = (state_q != IDLE);
    o_done = done_q;
    issue  = (state_q == RUN) && (credits_used < 2'd2);
  end

  // Two-entry FIFO with the head fixed in slot 0; a pop shifts slot 1 down before the write lands.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      issue_cnt     <= '0;
      flight_tag    <= '0;
      inflight      <= 1'b0;
      occ           <= 2'd0;
      done_q        <= 1'b0;
      fifo_value[0] <= '0;
      fifo_value[1] <= '0;
      fifo_round[0] <= '0;
      fifo_round[1] <= '0;
    end else if (i_abort) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == DRAIN) && drain_empty;
      if (start_run) begin
        issue_cnt <= '0;
      end else if (issue && (issue_cnt != LAST_IDX)) begin
        issue_cnt <= issue_cnt + ADDR_W'(1);
      end
      if (issue) begin
        flight_tag <= issue_cnt;
      end
      inflight <= issue;
      if (pop) begin
        fifo_value[0] <= fifo_value[1];
        fifo_round[0] <= fifo_round[1];
      end
      if (inflight) begin
        fifo_value[wr_slot] <= i_coef_value;
        fifo_round[wr_slot] <= flight_tag;
      end
      occ <= occ_after_pop + {1'b0, inflight};
    end
  end

  always_comb begin
    o_coef_num = issue_cnt;
    o_k_valid  = (occ != 2'd0);
    o_k_value  = o_k_valid ? fifo_value[0] : '0;
    o_k_round  = o_k_valid ? fifo_round[0] : '0;
    o_k_last   = o_k_valid && (fifo_round[0] == LAST_IDX);
  end

`ifdef SHA256_COEF_XOR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || start_run) begin
      o_coef_xor <= '0;
    end else if (pop && !i_abort) begin
      o_coef_xor <= o_coef_xor ^ o_k_value;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_coef_reader.sv
// Bench for sha256_coef_reader: vector table, full-rate, random backpressure, abort, reset and ROUNDS=1 runs against a ROM model.
`timescale 1ns/1ps
module tb_sha256_coef_reader;
  localparam int ROUNDS = 64;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_abort = 1'b0, i_k_ready = 1'b0;
  logic        o_busy, o_done, o_k_valid, o_k_last;
  logic [5:0]  o_coef_num, o_k_round;
  logic [31:0] i_coef_value, o_k_value;
  logic        s_start = 1'b0;
  logic        s_busy, s_done, s_valid, s_last;
  logic [5:0]  s_coef_num, s_round;
  logic [31:0] s_coef_value, s_value;
`ifdef SHA256_COEF_XOR_EN
  logic [31:0] o_coef_xor, s_coef_xor;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    bit          start;
    bit          ready;
    bit          abort;
    bit          busy;
    bit          valid;
    int          round;
    logic [31:0] value;
    int          coef;
    bit          done;
  } vec_t;
  vec_t vecs [20];

  always #5 i_clk = ~i_clk;

  // Registered ROM models: data for the index presented on the previous edge
  always @(posedge i_clk) begin
    i_coef_value <= K[o_coef_num];
    s_coef_value <= K[s_coef_num];
  end

  sha256_coef_reader #(.ROUNDS(ROUNDS), .ADDR_W(6), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_coef_num(o_coef_num), .i_coef_value(i_coef_value),
    .o_k_valid(o_k_valid), .i_k_ready(i_k_ready), .o_k_value(o_k_value), .o_k_round(o_k_round),
`ifdef SHA256_COEF_XOR_EN
    .o_coef_xor(o_coef_xor),
`endif
    .o_k_last(o_k_last));

  sha256_coef_reader #(.ROUNDS(1), .ADDR_W(6), .DATA_W(32)) dut_one (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(s_start), .i_abort(1'b0),
    .o_busy(s_busy), .o_done(s_done), .o_coef_num(s_coef_num), .i_coef_value(s_coef_value),
    .o_k_valid(s_valid), .i_k_ready(1'b1), .o_k_value(s_value), .o_k_round(s_round),
`ifdef SHA256_COEF_XOR_EN
    .o_coef_xor(s_coef_xor),
`endif
    .o_k_last(s_last));

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Move to 1 ns after the next rising edge; sampling and driving both happen there
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    while (!(o_k_valid && (o_k_round == 6'(r))) && n < 400) begin
      tick();
      n++;
    end
    check("wait for round", {o_k_valid, o_k_round}, {1'b1, 6'(r)});
  endtask

  task automatic full_rate_run();
    logic [31:0] x = '0;
    i_k_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("fr busy after E0", {o_busy, o_k_valid}, 2'b10);
    tick();
    check("fr no valid after E1", o_k_valid, 1'b0);
    tick();
    for (int t = 0; t < ROUNDS; t++) begin
      check("fr entry", {o_k_valid, o_done, o_k_last, o_k_round, o_k_value},
            {1'b1, 1'b0, (t == ROUNDS - 1), 6'(t), K[t]});
      x ^= K[t];
      tick();
    end
    check("fr done", {o_done, o_busy, o_k_valid}, 3'b100);
`ifdef SHA256_COEF_XOR_EN
    check("fr xor", o_coef_xor, x);
`endif
    tick();
    check("fr done pulse", o_done, 1'b0);
  endtask

  task automatic random_run();
    int          exp_t = 0;
    int          cycles = 0;
    bit          stalled = 1'b0;
    logic [39:0] held = '0;
    logic [31:0] x = '0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (exp_t < ROUNDS && cycles < 2000) begin
      if (stalled) check("bp stable", {o_k_valid, o_k_last, o_k_round, o_k_value}, held);
      check("bp busy", {o_busy, o_done}, 2'b10);
      i_k_ready = 1'($urandom_range(0, 1));
      i_start = ($urandom_range(0, 7) == 0);
      if (o_k_valid && i_k_ready) begin
        check("bp entry", {o_k_last, o_k_round, o_k_value}, {(exp_t == ROUNDS - 1), 6'(exp_t), K[exp_t]});
        x ^= K[exp_t];
        exp_t++;
      end
      stalled = o_k_valid && !i_k_ready;
      held = {o_k_valid, o_k_last, o_k_round, o_k_value};
      cycles++;
      tick();
    end
    i_k_ready = 1'b0;
    i_start = 1'b0;
    check("bp transfer count", exp_t, ROUNDS);
    check("bp done", {o_done, o_busy, o_k_valid}, 3'b100);
`ifdef SHA256_COEF_XOR_EN
    check("bp xor", o_coef_xor, x);
`endif
    tick();
    check("bp done pulse", o_done, 1'b0);
  endtask

  initial begin
    bit seen = 1'b0;

    vecs[0]  = '{1, 0, 0, 0, 0, -1, 32'h0, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, -1, 32'h0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, -1, 32'h0, 1, 0};
    for (int i = 3; i <= 12; i++) vecs[i] = '{0, 0, 0, 1, 1, 0, K[0], 2, 0};
    vecs[13] = '{0, 1, 0, 1, 1, 0, K[0], 2, 0};
    vecs[14] = '{0, 1, 0, 1, 1, 1, K[1], 3, 0};
    vecs[15] = '{0, 1, 0, 1, 1, 2, K[2], 4, 0};
    vecs[16] = '{0, 0, 1, 1, 1, 3, K[3], 5, 0};
    vecs[17] = '{0, 0, 0, 0, 0, -1, 32'h0, -1, 0};
    vecs[18] = '{1, 0, 1, 0, 0, -1, 32'h0, -1, 0};
    vecs[19] = '{0, 0, 0, 0, 0, -1, 32'h0, -1, 0};

    repeat (3) tick();
    i_rst_n = 1'b1;
    check("reset outputs", {o_busy, o_done, o_k_valid, o_k_last, o_k_round, o_k_value, o_coef_num}, '0);
    check("reset outputs r1", {s_busy, s_done, s_valid, s_last, s_round, s_value}, '0);

    // Start, stall ten cycles from the first valid, release, then abort and abort+start
    for (int i = 0; i < 20; i++) begin
      i_start = vecs[i].start;
      i_k_ready = vecs[i].ready;
      i_abort = vecs[i].abort;
      check("vec busy/valid/done", {o_busy, o_k_valid, o_done}, {vecs[i].busy, vecs[i].valid, vecs[i].done});
      if (vecs[i].valid) check("vec entry", {o_k_round, o_k_value}, {6'(vecs[i].round), vecs[i].value});
      if (vecs[i].coef >= 0) check("vec coef num", o_coef_num, 6'(vecs[i].coef));
      tick();
    end

    full_rate_run();
    random_run();
    random_run();

    // Abort at round 20 while stalled
    i_k_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_round(20);
    i_k_ready = 1'b0;
    tick();
    tick();
    check("abort stall hold", {o_k_valid, o_k_round, o_k_value}, {1'b1, 6'd20, K[20]});
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort cleared", {o_busy, o_k_valid, o_done}, 3'b000);
    seen = 1'b0;
    repeat (5) begin
      seen |= o_done;
      tick();
    end
    check("abort no done", seen, 1'b0);
    full_rate_run();

    // Synchronous reset at round 40
    i_k_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_round(40);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check("mid-run reset", {o_busy, o_done, o_k_valid, o_k_last, o_k_round, o_k_value, o_coef_num}, '0);
    seen = 1'b0;
    repeat (4) begin
      seen |= o_done | o_busy | o_k_valid;
      tick();
    end
    check("reset no done", seen, 1'b0);
    full_rate_run();

    // ROUNDS=1 instance
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("r1 busy", {s_busy, s_valid}, 2'b10);
    tick();
    check("r1 no valid E1", s_valid, 1'b0);
    tick();
    check("r1 entry", {s_valid, s_last, s_done, s_round, s_value}, {1'b1, 1'b1, 1'b0, 6'd0, K[0]});
    tick();
    check("r1 done", {s_done, s_busy, s_valid}, 3'b100);
`ifdef SHA256_COEF_XOR_EN
    check("r1 xor", s_coef_xor, K[0]);
`endif
    tick();
    check("r1 done pulse", s_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sha256_coef_reader.md
Name: sha256_coef_reader

Overview:
- Consumer/reader side of the registered SHA-256 round-constant ROM: address in, K value out one clock later.
- Drives the ROM coefficient index, absorbs the 1-cycle ROM read latency and presents K_t as a valid/ready stream with round tag to the compression datapath.
- Supports full-rate (1 K/cycle) streaming and arbitrary downstream backpressure without losing or duplicating coefficients.

Parameters:
- ROUNDS, 64, number of coefficients streamed per run, indices 0..ROUNDS-1; legal 1..64.
- ADDR_W, 6, ROM index width.
- DATA_W, 32, coefficient width.

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  start a run; sampled only in IDLE.
- i_abort  in  1  synchronous abort; highest priority after reset.
- o_busy  out  1  high from the start edge until the run ends.
- o_done  out  1  one-cycle pulse after the last handshake.
- o_coef_num  out  ADDR_W  index to the ROM.
- i_coef_value  in  DATA_W  ROM registered data for the index presented on the previous edge.
- o_k_valid  out  1  output entry valid.
- i_k_ready  in  1  downstream accepts.
- o_k_value  out  DATA_W  K_t.
- o_k_round  out  ADDR_W  t of the presented entry.
- o_k_last  out  1  high with the entry t = ROUNDS-1.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - State goes to IDLE.
  - o_busy, o_done, o_k_valid, o_k_last = 0; o_k_value = 0; o_k_round = 0; o_coef_num = 0.
  - Buffer and in-flight flag cleared.
  - Reset mid-run discards everything; no o_done.
- FSM IDLE -> RUN -> DRAIN -> IDLE:
  - IDLE: i_start=1 at an edge -> RUN; issue counter cleared to 0; o_busy=1.
  - RUN: o_coef_num = issue counter.
    - An issue occurs in a cycle when occupancy + inflight < 2 (2-entry output FIFO).
    - At the issue edge the counter increments and the inflight flag is set.
    - At the following edge i_coef_value is written to the FIFO tail, tagged with the issued index.
    - After the issue of index ROUNDS-1 -> DRAIN.
  - DRAIN: no issues. When the FIFO is empty and no read is in flight after the last handshake -> IDLE. o_done pulses one cycle; o_busy drops in that same cycle.
- Latency and throughput:
  - i_start sampled at edge E0 -> o_k_valid first high after edge E2 with round 0.
  - With i_k_ready held at 1: one entry per cycle, no bubbles, ROUNDS consecutive valid cycles.
  - o_done is high in the cycle after the last handshake.
- Handshake:
  - A transfer happens when o_k_valid & i_k_ready.
  - While o_k_valid=1 and i_k_ready=0, o_k_value, o_k_round and o_k_last are held stable.
  - The FIFO head is the output. Simultaneous write and read at full occupancy cannot occur (credit rule). Write and read at occupancy 1 keeps occupancy at 1.
- i_start while busy is ignored.
- i_abort=1 at an edge, any state:
  - Flush the FIFO, drop the in-flight read, go to IDLE.
  - o_busy=0 and o_k_valid=0 next cycle; no o_done.
  - If i_start=1 on the same edge as i_abort, i_start is ignored.
- ROUNDS=1: a single entry with o_k_last=1, then o_done.
- Counters saturate at ROUNDS-1; no wrap past index 63.

Optional Feature:
- Macro SHA256_COEF_XOR_EN.
- Defined:
  - Adds port o_coef_xor (out, DATA_W), cleared to 0 on reset and on the start edge.
  - On each handshake, o_coef_xor <= o_coef_xor ^ o_k_value.
  - Holds its value after o_done until the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- ROUNDS=64, i_k_ready=1, ROM model attached, i_start pulse at E0:
  - valid after E2 for 64 consecutive cycles.
  - Round 0 = 0x428a2f98, round 1 = 0x71374491, round 63 = 0xc67178f2 with o_k_last=1.
  - o_done pulse one cycle after the last handshake.
- Backpressure: i_k_ready random at 50%, ROUNDS=64. Exactly 64 transfers, rounds 0..63 in order, no duplicates; output stable while stalled; ROM values match.
- i_k_ready=0 for 10 cycles after the first valid: o_coef_num stops advancing at index 2, FIFO holds rounds 0 and 1. On release, rounds 0 and 1 then 2 are delivered back-to-back.
- i_abort at round 20 under stall: next cycle o_busy=0 and o_k_valid=0, no o_done. A new start restarts from round 0 with 0x428a2f98.
- Synchronous reset (i_rst_n=0 for one edge) mid-run at round 40: all outputs 0 next cycle. i_start during busy is ignored, with no counter reset.
- SHA256_COEF_XOR_EN defined, ROUNDS=2, ready=1: o_coef_xor = 0x33bd6b09 after o_done; ROUNDS=1 gives 0x428a2f98.
